radar_frame_parser: RTL

Consumes the received-byte Avalon-ST stream from the radar UART (the `from_uart` data/valid/ready/error interface of the serial core) and decodes the radar's framed serial protocol into speed measurements. It hunts for sync, validates length and XOR checksum, enforces an inter-byte timeout, and publishes speed, direction and an over-limit flag to the traffic-monitoring logic. It also keeps saturating good/bad frame counters for diagnostics.

---
 rtl/radar_frame_parser.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/radar_frame_parser.sv
// Radar serial frame decoder: hunts for AA 55 sync, checks length and XOR
// checksum, applies an inter-byte timeout and publishes speed reports.
module radar_frame_parser #(
    parameter int MAX_LEN     = 8,
    parameter int SPEED_LIMIT = 600,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [7:0]  from_uart_data,
    input  logic        from_uart_valid,
    input  logic        from_uart_error,
    output logic        from_uart_ready,
    output logic [15:0] speed,
    output logic        direction,
    output logic        over_limit,
    output logic        speed_valid,
    output logic        frame_ok,
    output logic [15:0] ok_count,
    output logic [15:0] err_count
);

    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]   LIMIT    = 16'(SPEED_LIMIT);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        HUNT, SYNC2, TYPE, LEN, PAYLOAD, CHK
    } state_e;

    state_e st_q, st_d;

    logic          ready_q;
    logic [7:0]    type_q, type_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [15:0]   speed_q, speed_d;
    logic          dir_q, dir_d;
    logic          ovl_q, ovl_d;
    logic          sv_q, fok_q;
    logic [15:0]   okc_q, okc_d, errc_q, errc_d;

    logic beat, good_beat, active, tmo_hit, bad_len, last_byte, chk_match;
    logic cnt_ok, cnt_err, load_spd;

    assign beat      = from_uart_valid && ready_q;
    assign good_beat = beat && !from_uart_error;
    assign active    = (st_q == TYPE) || (st_q == LEN) ||
                       (st_q == PAYLOAD) || (st_q == CHK);
    // An accepted beat in the same cycle as expiry takes priority.
    assign tmo_hit   = active && !beat && (tmo_q == TMO_LAST);
    assign bad_len   = (from_uart_data == 8'h00) || (from_uart_data > LEN_MAX);
    assign last_byte = ((idx_q + 8'd1) == len_q);
    assign chk_match = (chk_q == from_uart_data);

    // ---------------- state register ----------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) st_q <= HUNT;
        else             st_q <= st_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        st_d = st_q;
        if (beat) begin
            if (from_uart_error) begin
                st_d = HUNT;
            end else begin
                case (st_q)
                    HUNT:    if (from_uart_data == 8'hAA) st_d = SYNC2;
                    SYNC2: begin
                        if (from_uart_data == 8'h55)      st_d = TYPE;
                        else if (from_uart_data == 8'hAA) st_d = SYNC2;
                        else                              st_d = HUNT;
                    end
                    TYPE:    st_d = LEN;
                    LEN:     st_d = bad_len ? HUNT : PAYLOAD;
                    PAYLOAD: if (last_byte) st_d = CHK;
                    CHK:     st_d = HUNT;
                    default: st_d = HUNT;
                endcase
            end
        end else if (tmo_hit) begin
            st_d = HUNT;
        end
    end

    // ---------------- output / event logic ----------------
    always_comb begin
        cnt_ok   = good_beat && (st_q == CHK) && chk_match;
        cnt_err  = tmo_hit
                || (beat && from_uart_error && active)
                || (good_beat && (st_q == LEN) && bad_len)
                || (good_beat && (st_q == CHK) && !chk_match);
        load_spd = cnt_ok && (type_q == 8'h01) && (len_q >= 8'd3);
    end

    // ---------------- frame datapath ----------------
    always_comb begin
        type_d = type_q;
        len_d  = len_q;
        idx_d  = idx_q;
        chk_d  = chk_q;
        p0_d   = p0_q;
        p1_d   = p1_q;
        p2_d   = p2_q;
        if (good_beat) begin
            case (st_q)
                TYPE: begin
                    type_d = from_uart_data;
                    chk_d  = from_uart_data;
                end
                LEN: begin
                    len_d = from_uart_data;
                    idx_d = 8'd0;
                    chk_d = chk_q ^ from_uart_data;
                end
                PAYLOAD: begin
                    chk_d = chk_q ^ from_uart_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'd0) p0_d = from_uart_data;
                    if (idx_q == 8'd1) p1_d = from_uart_data;
                    if (idx_q == 8'd2) p2_d = from_uart_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (beat || !active || tmo_hit) tmo_d = '0;
        else                            tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ready_q <= 1'b0;
            type_q  <= 8'h00;
            len_q   <= 8'h00;
            idx_q   <= 8'h00;
            chk_q   <= 8'h00;
            p0_q    <= 8'h00;
            p1_q    <= 8'h00;
            p2_q    <= 8'h00;
            tmo_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            type_q  <= type_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            tmo_q   <= tmo_d;
        end
    end

    // ---------------- published results ----------------
    always_comb begin
        speed_d = speed_q;
        dir_d   = dir_q;
        ovl_d   = ovl_q;
        if (load_spd) begin
            speed_d = {p1_q, p2_q};
            dir_d   = p0_q[0];
            ovl_d   = ({p1_q, p2_q} > LIMIT);
        end
        okc_d  = (cnt_ok  && okc_q  != 16'hFFFF) ? okc_q  + 16'd1 : okc_q;
        errc_d = (cnt_err && errc_q != 16'hFFFF) ? errc_q + 16'd1 : errc_q;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            speed_q <= 16'h0000;
            dir_q   <= 1'b0;
            ovl_q   <= 1'b0;
            sv_q    <= 1'b0;
            fok_q   <= 1'b0;
            okc_q   <= 16'h0000;
            errc_q  <= 16'h0000;
        end else begin
            speed_q <= speed_d;
            dir_q   <= dir_d;
            ovl_q   <= ovl_d;
            sv_q    <= load_spd;
            fok_q   <= cnt_ok;
            okc_q   <= okc_d;
            errc_q  <= errc_d;
        end
    end

    assign from_uart_ready = ready_q;
    assign speed           = speed_q;
    assign direction       = dir_q;
    assign over_limit      = ovl_q;
    assign speed_valid     = sv_q;
    assign frame_ok        = fok_q;
    assign ok_count        = okc_q;
    assign err_count       = errc_q;

endmodule
